// File: rtl/nn_result_pkg.sv
// Shared types and constants for the neural-network result frame transmitter.
// Holds the FSM state encoding, the frame layout and the byte-selection helper.
package nn_result_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FRAME_LEN = 7;

    // Position of each byte inside the frame.
    localparam logic [2:0] IDX_SYNC  = 3'd0;
    localparam logic [2:0] IDX_IND   = 3'd1;
    localparam logic [2:0] IDX_R1_HI = 3'd2;
    localparam logic [2:0] IDX_R1_LO = 3'd3;
    localparam logic [2:0] IDX_R2_HI = 3'd4;
    localparam logic [2:0] IDX_R2_LO = 3'd5;
    localparam logic [2:0] IDX_CHK   = 3'd6;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Network result captured at the moment a frame is started.
    typedef struct packed {
        logic [15:0] rezultat_1;
        logic [15:0] rezultat_2;
        logic        indikator_1;
        logic        indikator_2;
    } snapshot_t;

    // Header/payload byte at a frame position; the checksum slot is filled elsewhere.
    function automatic logic [7:0] header_byte(input snapshot_t  s,
                                               input logic [7:0] sync,
                                               input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            IDX_SYNC:  b = sync;
            IDX_IND:   b = {6'b0, s.indikator_2, s.indikator_1};
            IDX_R1_HI: b = s.rezultat_1[15:8];
            IDX_R1_LO: b = s.rezultat_1[7:0];
            IDX_R2_HI: b = s.rezultat_2[15:8];
            IDX_R2_LO: b = s.rezultat_2[7:0];
            default:   b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/nn_result_checksum.sv
// Frame checksum: bitwise XOR of the six header and payload bytes.
module nn_result_checksum
    import nn_result_pkg::*;
(
    input  logic [5:0][7:0] frame_bytes,
    output logic [7:0]      chk
);

    // XOR-fold all bytes preceding the checksum slot
    always_comb begin
        chk = 8'h00;
        for (int i = 0; i < FRAME_LEN - 1; i++) begin
            chk = chk ^ frame_bytes[i];
        end
    end

endmodule

// File: rtl/neural_net_result_tx.sv
// Snapshots the neural-network result on a capture request and streams it
// out as a 7-byte frame over a valid/ready byte interface. Captures that
// arrive while a frame is in flight are dropped and counted.
module neural_net_result_tx
    import nn_result_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
    parameter int         DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic [15:0]           rezultat_1,
    input  logic [15:0]           rezultat_2,
    input  logic                  indikator_1,
    input  logic                  indikator_2,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    state_t          state;
    state_t          state_next;
    state_t          state_eff;
    logic [2:0]      index;
    logic [2:0]      index_next;
    snapshot_t       snap;
    logic            snap_load;
    logic            drop_inc;
    logic [5:0][7:0] frame_bytes;
    logic [7:0]      chk;

    // Header and payload bytes derived from the held snapshot
    always_comb begin
        for (int i = 0; i < FRAME_LEN - 1; i++) begin
            frame_bytes[i] = header_byte(snap, SYNC_BYTE, 3'(i));
        end
    end

    nn_result_checksum u_checksum (
        .frame_bytes (frame_bytes),
        .chk         (chk)
    );

    // Next-state, index, capture handling and frame outputs
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can
        // leave one unassigned, which would otherwise infer a latch.
        state_next = state;
        index_next = index;
        snap_load  = 1'b0;
        drop_inc   = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        busy       = 1'b0;
        frame_done = 1'b0;

        // An out-of-range index can only come from corruption; recover via IDLE.
        state_eff = state;
        if (state == ST_SEND && index > IDX_CHK) begin
            state_eff = ST_IDLE;
        end

        case (state_eff)
            ST_SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = (index == IDX_CHK) ? chk : header_byte(snap, SYNC_BYTE, index);
                drop_inc = capture;
                if (tx_ready) begin
                    if (index == IDX_CHK) begin
                        state_next = ST_DONE;
                        index_next = 3'd0;
                    end else begin
                        index_next = index + 3'd1;
                    end
                end
            end

            ST_DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                drop_inc   = capture;
                state_next = ST_IDLE;
            end

            default: begin
                // IDLE and any unused encoding
                index_next = 3'd0;
                if (capture) begin
                    snap_load  = 1'b1;
                    state_next = ST_SEND;
                end else begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    // FSM state and byte index registers
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples values from before the edge, independent of block order.
        if (rst) begin
            state <= ST_IDLE;
            index <= 3'd0;
        end else begin
            state <= state_next;
            index <= index_next;
        end
    end

    // Snapshot of the result inputs, loaded only when a frame is started
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the snapshot is a plain data register, but it is reset anyway
        // so a frame can never expose stale contents from before the reset.
        if (rst) begin
            snap <= '0;
        end else if (snap_load) begin
            snap <= '{rezultat_1:  rezultat_1,
                      rezultat_2:  rezultat_2,
                      indikator_1: indikator_1,
                      indikator_2: indikator_2};
        end
    end

    // Saturating count of captures rejected while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_inc && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_neural_net_result_tx.sv
// Self-checking bench for neural_net_result_tx: directed scenarios plus
// randomized frames, checked against a frame/drop-count reference model.
module tb_neural_net_result_tx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          capture;
    logic [15:0]   rezultat_1;
    logic [15:0]   rezultat_2;
    logic          indikator_1;
    logic          indikator_2;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          frame_done;
    logic [DW-1:0] drop_cnt;

    int         n_checks = 0;
    int         n_errors = 0;
    int         drop_model = 0;
    int         last_cycles = 0;
    logic [7:0] exp_frame [7];

    neural_net_result_tx #(
        .SYNC_BYTE  (8'hA5),
        .DROP_CNT_W (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .capture     (capture),
        .rezultat_1  (rezultat_1),
        .rezultat_2  (rezultat_2),
        .indikator_1 (indikator_1),
        .indikator_2 (indikator_2),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .frame_done  (frame_done),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: sync, indicators, results big-endian, XOR of the first six.
    task automatic build_frame(input logic [15:0] r1, input logic [15:0] r2,
                               input logic i1, input logic i2);
        exp_frame[0] = 8'hA5;
        exp_frame[1] = {6'b0, i2, i1};
        exp_frame[2] = r1[15:8];
        exp_frame[3] = r1[7:0];
        exp_frame[4] = r2[15:8];
        exp_frame[5] = r2[7:0];
        exp_frame[6] = 8'h00;
        for (int k = 0; k < 6; k++) exp_frame[6] = exp_frame[6] ^ exp_frame[k];
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic scramble_inputs();
        rezultat_1  = 16'($urandom);
        rezultat_2  = 16'($urandom);
        indikator_1 = 1'($urandom);
        indikator_2 = 1'($urandom);
    endtask

    // Starts a frame at a negedge with the DUT idle and receives it byte by byte.
    // Inputs are re-randomized every cycle; optional stalls, dropped captures and
    // a reset when the given byte index is presented.
    task automatic send_frame(input logic [15:0] r1, input logic [15:0] r2,
                              input logic i1, input logic i2,
                              input int stall_pct, input int stall_idx, input int stall_len,
                              input int drop_pct, input int n_drops, input int abort_idx,
                              input string tag);
        int idx = 0;
        int cyc = 0;
        int stalled = 0;
        int drops_left = n_drops;

        check({tag, ":idle_busy"}, busy, 1'b0);
        rezultat_1  = r1;
        rezultat_2  = r2;
        indikator_1 = i1;
        indikator_2 = i2;
        capture     = 1'b1;
        tx_ready    = 1'($urandom);
        build_frame(r1, r2, i1, i2);
        @(negedge clk);
        capture = 1'b0;

        while (idx < 7 && cyc < 1000) begin
            check({tag, ":valid"}, tx_valid, 1'b1);
            check({tag, ":data"}, tx_data, exp_frame[idx]);
            if (idx == abort_idx) begin
                rst      = 1'b1;
                tx_ready = 1'b0;
                #1;
                check({tag, ":rst_valid"}, tx_valid, 1'b0);
                check({tag, ":rst_busy"}, busy, 1'b0);
                check({tag, ":rst_done"}, frame_done, 1'b0);
                check({tag, ":rst_data"}, tx_data, 8'h00);
                check({tag, ":rst_drop"}, drop_cnt, 0);
                drop_model = 0;
                scramble_inputs();
                capture = 1'b1;
                @(negedge clk);
                check({tag, ":rst_hold_done"}, frame_done, 1'b0);
                rst     = 1'b0;
                capture = 1'b0;
                @(negedge clk);
                check({tag, ":post_rst_busy"}, busy, 1'b0);
                check({tag, ":post_rst_done"}, frame_done, 1'b0);
                return;
            end
            scramble_inputs();
            capture = 1'b0;
            if (drops_left > 0) begin
                capture = 1'b1;
                drops_left--;
            end else if ($urandom_range(99) < drop_pct) begin
                capture = 1'b1;
            end
            if (capture) drop_model = sat_inc(drop_model);
            if (idx == stall_idx && stalled < stall_len) begin
                tx_ready = 1'b0;
                stalled++;
            end else begin
                tx_ready = ($urandom_range(99) >= stall_pct);
            end
            if (tx_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        last_cycles = cyc;
        if (idx < 7) check({tag, ":timeout_idx"}, idx, 7);

        check({tag, ":done_valid"}, tx_valid, 1'b0);
        check({tag, ":done_pulse"}, frame_done, 1'b1);
        check({tag, ":done_busy"}, busy, 1'b1);
        tx_ready = 1'($urandom);
        capture  = (drop_pct > 0) ? 1'($urandom) : 1'b0;
        if (capture) drop_model = sat_inc(drop_model);
        @(negedge clk);
        capture  = 1'b0;
        tx_ready = 1'b0;
        check({tag, ":after_pulse"}, frame_done, 1'b0);
        check({tag, ":after_busy"}, busy, 1'b0);
        check({tag, ":after_valid"}, tx_valid, 1'b0);
        check({tag, ":drop_cnt"}, drop_cnt, drop_model);
    endtask

    initial begin
        rst         = 1'b1;
        capture     = 1'b0;
        tx_ready    = 1'b0;
        rezultat_1  = '0;
        rezultat_2  = '0;
        indikator_1 = 1'b0;
        indikator_2 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset:valid", tx_valid, 1'b0);
        check("reset:data", tx_data, 8'h00);
        check("reset:busy", busy, 1'b0);
        check("reset:done", frame_done, 1'b0);
        check("reset:drop", drop_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // Scenario 1: known frame, ready always high, 7 back-to-back bytes
        send_frame(16'h1234, 16'hABCD, 1'b1, 1'b0, 0, -1, 0, 0, 0, -1, "s1");
        check("s1:byte_cycles", last_cycles, 7);
        check("s1:chk_byte", exp_frame[6], 8'hE4);

        // Scenario 2: all-zero inputs
        send_frame(16'h0000, 16'h0000, 1'b0, 1'b0, 0, -1, 0, 0, 0, -1, "s2");
        check("s2:byte_cycles", last_cycles, 7);

        // Scenario 3: five-cycle stall on byte 3
        send_frame(16'h1234, 16'hABCD, 1'b1, 1'b0, 0, 3, 5, 0, 0, -1, "s3");
        check("s3:byte_cycles", last_cycles, 12);

        // Scenario 4: inputs churn after capture, three extra captures
        send_frame(16'($urandom), 16'($urandom), 1'b0, 1'b1, 0, -1, 0, 0, 3, -1, "s4");
        check("s4:drop_three", drop_cnt, 3);

        // Randomized frames with stalls and dropped captures
        for (int f = 0; f < 10; f++) begin
            send_frame(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                       30, -1, 0, 20, 0, -1, "rand");
        end

        // Scenario 5: reset while byte 4 is presented, then a clean frame
        send_frame(16'($urandom), 16'($urandom), 1'b1, 1'b1, 0, -1, 0, 0, 0, 4, "s5");
        send_frame(16'($urandom), 16'($urandom), 1'b1, 1'b0, 0, -1, 0, 0, 0, -1, "s5_next");

        // Scenario 6: 300 captures while stalled on byte 0 saturate the counter
        send_frame(16'($urandom), 16'($urandom), 1'b0, 1'b1, 0, 0, 300, 0, 300, -1, "s6");
        check("s6:drop_sat", drop_cnt, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
